// File: rtl/pengo_ram_arbiter_pkg.sv
// pengo_arb_pkg: shared types and sizing helpers for the Pengo work-RAM
// arbiter (state encoding, default bus widths, timer width calculation).
package pengo_arb_pkg;

    localparam int AW_DEF = 12;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PAUSE = 2'd1,
        ST_GRANT = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_e;

    // Width of the shared down-counter. It must hold DRAIN-1 always, and
    // TIMEOUT-1 only when the acknowledge timeout is built in.
    function automatic int cnt_width(input int timeout, input int drain, input bit use_timeout);
        int w_t;
        int w_d;
        w_d = $clog2(drain + 1);
        w_t = $clog2(timeout + 1);
        if (use_timeout && (w_t > w_d)) begin
            cnt_width = w_t;
        end else begin
            cnt_width = w_d;
        end
        if (cnt_width < 1) begin
            cnt_width = 1;
        end
    endfunction

endpackage

// File: rtl/pengo_ram_arbiter_if.sv
// pengo_ram_arbiter_if: bundles the CPU, hiscore, pause and RAM-side signals
// of the work-RAM arbiter. The arbiter uses the slave view; the surrounding
// system (CPU core, hiscore engine, pause block, RAM) uses the master view.
interface pengo_ram_arbiter_if
    import pengo_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    // CPU side
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_we;
    logic [DW-1:0] cpu_rdata;
    // hiscore side
    logic          hs_req;
    logic [AW-1:0] hs_addr;
    logic [DW-1:0] hs_wdata;
    logic          hs_we;
    logic          hs_rd;
    logic          hs_gnt;
    logic [DW-1:0] hs_rdata;
    logic          hs_rvalid;
    logic          hs_err;
    // pause block handshake
    logic          pause_req;
    logic          paused;
    // single-port RAM
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we,
        output cpu_rdata,
        input  hs_req, hs_addr, hs_wdata, hs_we, hs_rd,
        output hs_gnt, hs_rdata, hs_rvalid, hs_err,
        output pause_req,
        input  paused,
        output ram_addr, ram_wdata, ram_we,
        input  ram_rdata
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_we,
        input  cpu_rdata,
        output hs_req, hs_addr, hs_wdata, hs_we, hs_rd,
        input  hs_gnt, hs_rdata, hs_rvalid, hs_err,
        input  pause_req,
        output paused,
        input  ram_addr, ram_wdata, ram_we,
        output ram_rdata
    );

endinterface

// File: rtl/pengo_ram_arbiter_timer.sv
// pengo_arb_timer: loadable down-counter that stops at zero. done_o is high
// whenever the count is zero. The arbiter reuses it for the drain interval
// and, when built in, the pause-acknowledge timeout.
module pengo_arb_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: a load wins, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/pengo_ram_arbiter.sv
// pengo_ram_arbiter: shares the Pengo work-RAM port between the Z80 and the
// hiscore save/restore engine. The CPU is halted through the pause block
// before the port is handed to hiscore, and the pause is held for a short
// drain interval after release so the CPU never sees a half-finished access.
// Build macro PENGO_RAM_ARB_TIMEOUT_EN bounds the wait for pause acknowledge
// and reports an aborted request with a one-cycle hs_err pulse.
module pengo_ram_arbiter
    import pengo_arb_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int DRAIN   = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic reset,
    pengo_ram_arbiter_if.slave bus
);

`ifdef PENGO_RAM_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int           CW         = cnt_width(TIMEOUT, DRAIN, TMO_EN);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN - 1);
`ifdef PENGO_RAM_ARB_TIMEOUT_EN
    localparam logic [CW-1:0] TMO_LOAD   = CW'(TIMEOUT - 1);
`endif

    arb_state_e state_q;
    arb_state_e state_d;

    logic pause_req_q;
    logic pause_req_d;
    logic hs_gnt_q;
    logic hs_gnt_d;
    logic hs_rvalid_q;
    logic hs_rvalid_d;

    logic          tmr_load_s;
    logic [CW-1:0] tmr_val_s;
    logic          tmr_done_s;
    logic          tmo_fire_s;
    logic          abort_s;

    logic [AW-1:0] ram_addr_s;
    logic [DW-1:0] ram_wdata_s;
    logic          ram_we_s;

    pengo_arb_timer #(
        .W (CW)
    ) u_timer (
        .clk    (clk),
        .rst    (reset),
        .load_i (tmr_load_s),
        .val_i  (tmr_val_s),
        .done_o (tmr_done_s)
    );

    // Session sequencing: request, wait for the CPU to halt, grant, drain.
    always_comb begin
        state_d    = state_q;
        tmr_load_s = 1'b0;
        tmr_val_s  = DRAIN_LOAD;
        tmo_fire_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.hs_req && !abort_s) begin
                    state_d = ST_PAUSE;
`ifdef PENGO_RAM_ARB_TIMEOUT_EN
                    tmr_load_s = 1'b1;
                    tmr_val_s  = TMO_LOAD;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAUSE: begin
                if (!bus.hs_req) begin
                    state_d = ST_IDLE;
                end else if (bus.paused) begin
                    state_d = ST_GRANT;
`ifdef PENGO_RAM_ARB_TIMEOUT_EN
                end else if (tmr_done_s) begin
                    state_d    = ST_IDLE;
                    tmo_fire_s = 1'b1;
`endif
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_GRANT: begin
                if (!bus.hs_req) begin
                    state_d    = ST_DRAIN;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = DRAIN_LOAD;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            ST_DRAIN: begin
                if (tmr_done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs follow the next state so they line up with it.
    always_comb begin
        pause_req_d = (state_d != ST_IDLE);
        hs_gnt_d    = (state_d == ST_GRANT);
        if ((state_q == ST_GRANT) && bus.hs_rd && !bus.hs_we) begin
            hs_rvalid_d = 1'b1;
        end else begin
            hs_rvalid_d = 1'b0;
        end
    end

    // State and handshake output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pause_req_q <= 1'b0;
            hs_gnt_q    <= 1'b0;
            hs_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pause_req_q <= pause_req_d;
            hs_gnt_q    <= hs_gnt_d;
            hs_rvalid_q <= hs_rvalid_d;
        end
    end

`ifdef PENGO_RAM_ARB_TIMEOUT_EN
    logic hs_err_q;
    logic abort_q;
    logic abort_d;

    // Sticky abort: set by a timeout, cleared once hiscore drops its request.
    always_comb begin
        if (tmo_fire_s) begin
            abort_d = 1'b1;
        end else if (!bus.hs_req) begin
            abort_d = 1'b0;
        end else begin
            abort_d = abort_q;
        end
    end

    // Timeout error pulse and abort flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_err_q <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            hs_err_q <= tmo_fire_s;
            abort_q  <= abort_d;
        end
    end

    assign abort_s    = abort_q;
    assign bus.hs_err = hs_err_q;
`else
    assign abort_s    = 1'b0;
    assign bus.hs_err = 1'b0;
`endif

    // RAM port mux: CPU except in GRANT; writes are blocked in DRAIN and reset.
    always_comb begin
        ram_addr_s  = bus.cpu_addr;
        ram_wdata_s = bus.cpu_wdata;
        ram_we_s    = 1'b0;
        if (reset) begin
            ram_we_s = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_PAUSE: begin
                    ram_we_s = bus.cpu_we;
                end
                ST_GRANT: begin
                    ram_addr_s  = bus.hs_addr;
                    ram_wdata_s = bus.hs_wdata;
                    ram_we_s    = bus.hs_we;
                end
                ST_DRAIN: begin
                    ram_we_s = 1'b0;
                end
                default: begin
                    ram_we_s = 1'b0;
                end
            endcase
        end
    end

    assign bus.ram_addr  = ram_addr_s;
    assign bus.ram_wdata = ram_wdata_s;
    assign bus.ram_we    = ram_we_s;

    assign bus.cpu_rdata = bus.ram_rdata;
    assign bus.hs_rdata  = bus.ram_rdata;
    assign bus.hs_gnt    = hs_gnt_q;
    assign bus.hs_rvalid = hs_rvalid_q;
    assign bus.pause_req = pause_req_q;

endmodule

// File: tb/tb_pengo_ram_arbiter.sv
// Testbench for pengo_ram_arbiter: a RAM model plus a shadow memory as the
// reference, random CPU/hiscore traffic, and a scoreboard of expected reads
// drained by an independent monitor.
`timescale 1ns/1ps
module tb_pengo_ram_arbiter;
    import pengo_arb_pkg::*;

    localparam int AW      = 12;
    localparam int DW      = 8;
    localparam int DRAIN   = 2;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    int   err_at = -1;
    int   err_seen = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            at;
    } rd_t;
    rd_t exp_q[$];

    logic [DW-1:0] mem    [0:(1<<AW)-1];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    logic [AW-1:0] pool   [0:7];

    pengo_ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    pengo_ram_arbiter #(
        .AW(AW), .DW(DW), .DRAIN(DRAIN), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM with registered read data.
    always @(posedge clk) begin
        if (bus.ram_we === 1'b1) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor: every rvalid must match the oldest expected read, on time.
    always @(negedge clk) begin : monitor
        rd_t e;
        if (bus.hs_rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", 32'(bus.hs_rdata), 32'(e.data));
                check("rd_latency", cyc, e.at);
            end
        end else if (exp_q.size() != 0 && exp_q[0].at <= cyc) begin
            e = exp_q.pop_front();
            check("rvalid_missing", 32'd0, 32'd1);
        end
        if (bus.hs_err === 1'b1) begin
            err_seen++;
            check("hs_err_cycle", cyc, err_at);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_read(input logic [AW-1:0] a);
        rd_t e;
        e.data = shadow[a];
        e.at   = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic idle_activity(input int n);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        for (int k = 0; k < n; k++) begin
            a = pool[$urandom_range(7)];
            d = DW'($urandom);
            case ($urandom_range(0, 2))
                0: begin
                    bus.cpu_we = 1'b1; bus.cpu_addr = a; bus.cpu_wdata = d;
                    shadow[a] = d;
                    #1 check("idle_cpu_we", 32'(bus.ram_we), 32'd1);
                    step();
                    bus.cpu_we = 1'b0;
                end
                1: begin
                    bus.cpu_we = 1'b0; bus.cpu_addr = a;
                    step();
                    check("cpu_rdata", 32'(bus.cpu_rdata), 32'(shadow[a]));
                end
                default: begin
                    bus.hs_we = 1'b1; bus.hs_rd = 1'b1; bus.hs_addr = a; bus.hs_wdata = d;
                    #1 check("stray_hs_we", 32'(bus.ram_we), 32'd0);
                    step();
                    bus.hs_we = 1'b0; bus.hs_rd = 1'b0;
                end
            endcase
        end
    endtask

    task automatic req_and_grant(input int pdly);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bus.hs_req = 1'b1;
        step();
        check("pause_req_rise", 32'(bus.pause_req), 32'd1);
        check("gnt_early", 32'(bus.hs_gnt), 32'd0);
        for (int k = 0; k < pdly; k++) begin
            if ($urandom_range(1) == 1) begin
                a = pool[$urandom_range(7)];
                d = DW'($urandom);
                bus.cpu_we = 1'b1; bus.cpu_addr = a; bus.cpu_wdata = d;
                shadow[a] = d;
                #1 check("pause_cpu_we", 32'(bus.ram_we), 32'd1);
            end else begin
                bus.cpu_we = 1'b0;
            end
            step();
            check("gnt_wait", 32'(bus.hs_gnt), 32'd0);
            check("pause_req_hold", 32'(bus.pause_req), 32'd1);
        end
        bus.cpu_we = 1'b0;
        bus.paused = 1'b1;
        step();
        check("gnt_rise", 32'(bus.hs_gnt), 32'd1);
        check("pause_req_grant", 32'(bus.pause_req), 32'd1);
    endtask

    task automatic hs_op(input bit we, input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit cwe, input logic [DW-1:0] cd, input logic [AW-1:0] ca);
        bus.hs_we = we; bus.hs_rd = rd; bus.hs_addr = a; bus.hs_wdata = d;
        bus.cpu_we = cwe; bus.cpu_wdata = cd; bus.cpu_addr = ca;
        if (we) shadow[a] = d;
        else if (rd) push_read(a);
        #1 check("grant_ram_we", 32'(bus.ram_we), 32'(we));
        if (we || rd) check("grant_ram_addr", 32'(bus.ram_addr), 32'(a));
        step();
        bus.hs_we = 1'b0; bus.hs_rd = 1'b0;
    endtask

    task automatic release_port(input bit last_rd, input logic [AW-1:0] ra, input bit rereq);
        bus.hs_req = 1'b0;
        bus.cpu_we = 1'b1; bus.cpu_wdata = 8'hFF; bus.cpu_addr = 12'h123;
        if (last_rd) begin
            bus.hs_rd = 1'b1; bus.hs_addr = ra;
            push_read(ra);
        end
        step();
        bus.hs_rd = 1'b0;
        check("gnt_drop", 32'(bus.hs_gnt), 32'd0);
        check("drain_pause_req", 32'(bus.pause_req), 32'd1);
        if (rereq) bus.hs_req = 1'b1;
        #1 check("drain_we_gated", 32'(bus.ram_we), 32'd0);
        for (int k = 1; k < DRAIN; k++) begin
            step();
            check("drain_pause_req", 32'(bus.pause_req), 32'd1);
            check("drain_we_gated", 32'(bus.ram_we), 32'd0);
        end
        step();
        bus.cpu_we = 1'b0;
        bus.paused = 1'b0;
        check("pause_req_release", 32'(bus.pause_req), 32'd0);
        check("gnt_idle", 32'(bus.hs_gnt), 32'd0);
        if (rereq) begin
            step();
            check("rereq_pause", 32'(bus.pause_req), 32'd1);
            check("rereq_no_gnt", 32'(bus.hs_gnt), 32'd0);
            bus.hs_req = 1'b0;
            step();
            check("rereq_abort", 32'(bus.pause_req), 32'd0);
        end
    endtask

    initial begin : stim
        int n;
        int op;
        pool[0] = 12'h123; pool[1] = 12'h000; pool[2] = 12'hFFF; pool[3] = 12'h200;
        pool[4] = 12'h3A5; pool[5] = 12'h7FF; pool[6] = 12'h800; pool[7] = 12'h456;
        for (int i = 0; i < (1<<AW); i++) begin
            mem[i] = 8'h00;
            shadow[i] = 8'h00;
        end
        reset = 1'b1;
        bus.cpu_addr = 12'hABC; bus.cpu_wdata = 8'h00; bus.cpu_we = 1'b0;
        bus.hs_req = 1'b0; bus.hs_addr = 12'h000; bus.hs_wdata = 8'h00;
        bus.hs_we = 1'b0; bus.hs_rd = 1'b0; bus.paused = 1'b0;
        step();
        step();
        check("rst_pause_req", 32'(bus.pause_req), 32'd0);
        check("rst_hs_gnt", 32'(bus.hs_gnt), 32'd0);
        check("rst_hs_rvalid", 32'(bus.hs_rvalid), 32'd0);
        check("rst_hs_err", 32'(bus.hs_err), 32'd0);
        check("rst_mux_cpu", 32'(bus.ram_addr), 32'h0ABC);
        reset = 1'b0;
        step();

        // Basic session with CPU hammering 0x123 throughout GRANT and DRAIN.
        req_and_grant(3);
        hs_op(1'b1, 1'b0, 12'h123, 8'h5A, 1'b1, 8'hFF, 12'h123);
        hs_op(1'b0, 1'b1, 12'h123, 8'h00, 1'b1, 8'hFF, 12'h123);
        hs_op(1'b1, 1'b1, 12'h456, 8'hC3, 1'b1, 8'hFF, 12'h123);
        release_port(1'b1, 12'h123, 1'b0);
        bus.cpu_addr = 12'h123;
        step();
        check("cpu_iso_0x123", 32'(bus.cpu_rdata), 32'h5A);
        bus.cpu_we = 1'b1; bus.cpu_wdata = 8'h77; shadow[12'h123] = 8'h77;
        step();
        bus.cpu_we = 1'b0;
        step();
        check("cpu_idle_write", 32'(bus.cpu_rdata), 32'h77);

        // Abort while waiting for pause acknowledge.
        bus.hs_req = 1'b1;
        step();
        check("abort_pause_req", 32'(bus.pause_req), 32'd1);
        step();
        step();
        bus.hs_req = 1'b0;
        step();
        check("abort_pause_drop", 32'(bus.pause_req), 32'd0);
        check("abort_no_gnt", 32'(bus.hs_gnt), 32'd0);
        step();

`ifdef PENGO_RAM_ARB_TIMEOUT_EN
        // Acknowledge never arrives: error pulse after TIMEOUT PAUSE cycles.
        err_at = cyc + TIMEOUT + 1;
        bus.hs_req = 1'b1;
        for (int k = 1; k <= TIMEOUT; k++) begin
            step();
            if (k == 1 || k == TIMEOUT) check("tmo_pause_req", 32'(bus.pause_req), 32'd1);
        end
        step();
        check("tmo_pause_drop", 32'(bus.pause_req), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("tmo_no_rereq", 32'(bus.pause_req), 32'd0);
        end
        check("tmo_err_seen", err_seen, 32'd1);
        bus.hs_req = 1'b0;
        step();
        req_and_grant(1);
        release_port(1'b0, 12'h000, 1'b0);
`else
        // Without the timeout the request waits indefinitely.
        bus.hs_req = 1'b1;
        repeat (40) step();
        check("wait_pause_req", 32'(bus.pause_req), 32'd1);
        check("wait_no_gnt", 32'(bus.hs_gnt), 32'd0);
        bus.hs_req = 1'b0;
        step();
        check("wait_abort", 32'(bus.pause_req), 32'd0);
`endif

        // Reset asserted in the middle of a grant with a write in flight.
        req_and_grant(1);
        bus.hs_we = 1'b1; bus.hs_addr = 12'h200; bus.hs_wdata = 8'h11;
        #1 check("pre_rst_ram_we", 32'(bus.ram_we), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("arst_pause_req", 32'(bus.pause_req), 32'd0);
        check("arst_hs_gnt", 32'(bus.hs_gnt), 32'd0);
        check("arst_ram_we", 32'(bus.ram_we), 32'd0);
        bus.hs_we = 1'b0; bus.hs_req = 1'b0; bus.paused = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        req_and_grant(2);
        hs_op(1'b0, 1'b1, 12'h200, 8'h00, 1'b0, 8'h00, 12'h000);
        release_port(1'b0, 12'h000, 1'b0);

        // Random sessions with interleaved CPU traffic.
        for (int s = 0; s < 25; s++) begin
            idle_activity($urandom_range(1, 4));
            req_and_grant($urandom_range(0, 4));
            n = $urandom_range(3, 10);
            for (int k = 0; k < n; k++) begin
                op = $urandom_range(0, 3);
                hs_op(op == 0 || op == 2, op == 1 || op == 2, pool[$urandom_range(7)], DW'($urandom),
                      1'($urandom_range(1)), DW'($urandom), pool[$urandom_range(7)]);
            end
            release_port(1'($urandom_range(1)), pool[$urandom_range(7)], $urandom_range(3) == 0);
        end
        idle_activity(6);

        step();
        step();
        check("reads_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pengo_ram_arbiter.md
# pengo_ram_arbiter

Arbiter and sequencer for the Pengo work-RAM port shared by the Z80 CPU and the hiscore save/restore engine. It owns the pause handshake: on a hiscore request it asks the pause block to halt the CPU, waits for acknowledge, then switches the single-port RAM mux to the hiscore engine. On release it returns the port to the CPU and drops the pause request after a drain interval. It sits between the `pengo` core's RAM, the `hiscore` module and the `pause` module, all clocked on `clk_sys`.

## Interface
- AW, 12, RAM address width
- DW, 8, RAM data width
- DRAIN, 2, cycles pause stays asserted after hiscore release (1..15)
- TIMEOUT, 4096, max cycles waiting for pause acknowledge (only with timeout feature)

Ports:
- clk  in  1  system clock (clk_sys, 24 MHz)
- reset  in  1  asynchronous, active-high reset
- cpu_addr  in  AW  CPU RAM address
- cpu_wdata  in  DW  CPU write data
- cpu_we  in  1  CPU write strobe
- cpu_rdata  out  DW  RAM read data to CPU (ram_rdata pass-through)
- hs_req  in  1  hiscore requests ownership; level, held for whole session
- hs_addr  in  AW  hiscore address
- hs_wdata  in  DW  hiscore write data
- hs_we  in  1  hiscore write strobe
- hs_rd  in  1  hiscore read strobe
- hs_gnt  out  1  hiscore owns the port
- hs_rdata  out  DW  read data, valid with hs_rvalid
- hs_rvalid  out  1  one-cycle pulse, read data valid
- hs_err  out  1  one-cycle pulse, request aborted by timeout
- pause_req  out  1  to pause block: halt CPU
- paused  in  1  from pause block: CPU halted at a bus-cycle boundary
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_we  out  1  RAM write enable
- ram_rdata  in  DW  RAM read data, registered, 1-cycle latency

## Operation
- States: IDLE, PAUSE, GRANT, DRAIN.
- IDLE: the mux selects the CPU. pause_req=0, hs_gnt=0. If hs_req=1, go to PAUSE.
- PAUSE: pause_req=1 and the mux still selects the CPU. If paused=1 and hs_req=1, go to GRANT. If hs_req=0, abort to IDLE with no grant.
- GRANT: pause_req=1, hs_gnt=1, the mux selects hiscore.
  - ram_we = hs_we.
  - hs_rd without hs_we starts a read. hs_rdata=ram_rdata and hs_rvalid=1 on the next cycle.
  - hs_we and hs_rd together: the write wins, no rvalid.
  - hs_req=0: go to DRAIN.
- DRAIN: the mux returns to the CPU with CPU writes gated (ram_we=0). pause_req stays 1 for DRAIN cycles. A read issued on the last GRANT cycle still delivers its rvalid in the first DRAIN cycle. Then go to IDLE.
- hs_req re-asserted during DRAIN is ignored until IDLE. Re-entry then takes the full PAUSE path.
- hs_we/hs_rd outside GRANT are ignored.
- cpu_we is gated off in GRANT and DRAIN. In IDLE and PAUSE, cpu_we passes straight through.
- paused dropping during GRANT (user unpause): hs_gnt is held. The pause block must honour pause_req; no check is made.

## Timing
- Reset values: state=IDLE, pause_req=0, hs_gnt=0, hs_rvalid=0, hs_err=0, drain/timeout counters=0. The mux selects the CPU.
- All state outputs are registered. ram_* is a combinational mux from the state register and inputs.
- Grant latency: hs_req rises → pause_req at +1 cycle. paused seen at cycle N → hs_gnt at N+1. Minimum 2 cycles.
- Read latency: 1 cycle from hs_rd to hs_rvalid.
- Release: hs_req falls at cycle N → hs_gnt=0 at N+1 → pause_req=0 at N+1+DRAIN.
- Reset mid-session asserts asynchronously. All outputs go to reset values immediately and pause_req drops at once.

## Configuration
- PENGO_RAM_ARB_TIMEOUT_EN defined: a counter runs in PAUSE. If paused has not been seen after TIMEOUT cycles, then:
  - pulse hs_err for one cycle;
  - drop pause_req;
  - go to IDLE.
  hs_req must then drop before a new request is accepted; a sticky abort flag is cleared by hs_req=0.
- Not defined: PAUSE waits indefinitely, hs_err is tied to 0, and no counter is synthesized.

## Structure
- Package `pengo_arb_pkg`:
  - state enum (IDLE/PAUSE/GRANT/DRAIN);
  - default AW/DW localparams;
  - counter width helper ($clog2 of TIMEOUT+1 and DRAIN+1).
- Optional sub-module `pengo_arb_timer`: a loadable down-counter with done flag, reused for both DRAIN and TIMEOUT. The FSM and mux stay in the top.

## Test plan
- Basic session: hs_req=1, paused asserted 3 cycles after pause_req.
  - hs_gnt rises the cycle after paused.
  - Write 0x5A to 0x123, then read 0x123 → hs_rdata=0x5A with hs_rvalid exactly 1 cycle after hs_rd.
- CPU isolation: cpu_we=1 to 0x123 with data 0xFF throughout GRANT and DRAIN → RAM still reads 0x5A. In IDLE, the CPU write lands.
- Abort in PAUSE: drop hs_req before paused → returns to IDLE with hs_gnt never asserted; pause_req=0 the next cycle.
- Drain: with DRAIN=2, hs_req falls at cycle N → hs_gnt=0 at N+1, pause_req=0 at N+3. A read on the last GRANT cycle still yields rvalid at N+1.
- Timeout (macro on, TIMEOUT=16): paused held low → hs_err pulses at cycle 17 after entering PAUSE and the FSM returns to IDLE. Holding hs_req high causes no re-request until it toggles.
- Async reset asserted during GRANT → pause_req, hs_gnt and ram_we all 0 with no clock edge. After release, a new session succeeds.
